dispatch_unpacker: RTL

- Byte-stream front end that sits directly upstream of the network source stage.
- Accepts 8-bit instruction bytes from the host link (UART/FIFO) and assembles variable-length instructions, one opcode per instruction.
- Emits each instruction as a left-aligned `SRC_WIDTH-bit word on the source valid/ready handshake.
- Byte count per instruction is fixed by the opcode, so no length field is carried on the link.

---
 rtl/dispatch_unpacker_pkg.sv | 65 ++++++
 rtl/dispatch_unpacker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dispatch_unpacker_pkg.sv
// Shared configuration for the dispatch front end: network sizing, opcode map,
// per-opcode byte counts and the resulting source-word geometry.
package dispatch_unpacker_pkg;

    localparam int NET_NUM_INP         = 4;
    localparam int NET_CHARGE_WIDTH    = 8;
    localparam int NET_MAX_PERIOD      = 15;
    localparam int NET_MAX_NUM_PERIODS = 15;
    localparam int DEFAULT_RUN_WIDTH   = 16;

    localparam int NUM_OPS           = 5;
    localparam int OPC_WIDTH         = $clog2(NUM_OPS);
    localparam int IDX_WIDTH         = $clog2(NET_NUM_INP);
    localparam int PERIOD_WIDTH      = $clog2(NET_MAX_PERIOD + 1);
    localparam int NUM_PERIODS_WIDTH = $clog2(NET_MAX_NUM_PERIODS + 1);
    localparam int SPK_WIDTH         = IDX_WIDTH + NET_CHARGE_WIDTH;
    localparam int SPK_PRDC_WIDTH    = SPK_WIDTH + PERIOD_WIDTH + NUM_PERIODS_WIDTH;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_NOP      = 3'd0,
        OP_RUN      = 3'd1,
        OP_SPK      = 3'd2,
        OP_CLR      = 3'd3,
        OP_SPK_PRDC = 3'd4
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FULL
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int bytes_for(input int payload_width);
        return (OPC_WIDTH + payload_width + 7) / 8;
    endfunction

    localparam int PAYLOAD_WIDTH  = max2(max2(DEFAULT_RUN_WIDTH, SPK_WIDTH), SPK_PRDC_WIDTH);
    localparam int SRC_WIDTH      = OPC_WIDTH + PAYLOAD_WIDTH;
    localparam int BYTES_RUN      = bytes_for(DEFAULT_RUN_WIDTH);
    localparam int BYTES_SPK      = bytes_for(SPK_WIDTH);
    localparam int BYTES_SPK_PRDC = bytes_for(SPK_PRDC_WIDTH);
    localparam int MAX_BYTES      = max2(max2(1, BYTES_RUN), max2(BYTES_SPK, BYTES_SPK_PRDC));
    localparam int BYTE_CNT_WIDTH = $clog2(MAX_BYTES + 1);

    // Zero marks an opcode that has no instruction behind it.
    function automatic int op_num_bytes(input opcode_t op, input int run_width);
        case (op)
            OP_NOP:      return 1;
            OP_CLR:      return 1;
            OP_RUN:      return bytes_for(run_width);
            OP_SPK:      return bytes_for(SPK_WIDTH);
            OP_SPK_PRDC: return bytes_for(SPK_PRDC_WIDTH);
            default:     return 0;
        endcase
    endfunction

    function automatic int max_bytes(input int run_width);
        return max2(max2(1, bytes_for(run_width)), max2(BYTES_SPK, BYTES_SPK_PRDC));
    endfunction

endpackage

// File: rtl/dispatch_unpacker.sv
// Assembles opcode-sized byte groups from the host link into left-aligned
// source words, with same-cycle handover so single-byte ops stream at full rate.
module dispatch_unpacker
    import dispatch_unpacker_pkg::*;
#(
    parameter int RUN_WIDTH = DEFAULT_RUN_WIDTH
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic [SRC_WIDTH-1:0] src,
    output logic                 op_err
);

    localparam int NB    = max_bytes(RUN_WIDTH);
    localparam int ASM_W = NB * 8;
    localparam int CNT_W = $clog2(NB + 1);

    state_t             state, state_n;
    logic [ASM_W-1:0]   asm_reg, asm_n;
    logic [CNT_W-1:0]   byte_idx, idx_n;
    logic [CNT_W-1:0]   remaining, rem_n;
    logic               op_err_n;
    logic               byte_hs;
    logic               start;
    opcode_t            opc;
    logic [CNT_W-1:0]   first_cnt;
    logic [ASM_W-1:0]   lead;
    logic [ASM_W-SRC_WIDTH-1:0] pad_unused;

    assign in_ready   = (state == ST_FULL) ? src_ready : 1'b1;
    assign byte_hs    = in_valid && in_ready;
    assign opc        = opcode_t'(in_byte[7 -: OPC_WIDTH]);
    assign first_cnt  = CNT_W'(op_num_bytes(opc, RUN_WIDTH));
    assign src_valid  = (state == ST_FULL);
    assign src        = asm_reg[ASM_W-1 -: SRC_WIDTH];
    assign pad_unused = asm_reg[ASM_W-SRC_WIDTH-1:0];

    always_comb begin
        lead = '0;
        lead[ASM_W-1 -: 8] = in_byte;
    end

    // Next-state logic; a first byte can arrive in IDLE or as FULL hands off.
    always_comb begin
        state_n  = state;
        asm_n    = asm_reg;
        idx_n    = byte_idx;
        rem_n    = remaining;
        op_err_n = 1'b0;
        start    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                start = byte_hs;
            end
            ST_COLLECT: begin
                if (byte_hs) begin
                    asm_n = asm_reg | (lead >> {byte_idx, 3'b000});
                    idx_n = byte_idx + CNT_W'(1);
                    rem_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_n = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (src_ready) begin
                    if (in_valid) begin
                        start = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (start) begin
            asm_n = '0;
            idx_n = '0;
            rem_n = '0;
            if (first_cnt == '0) begin
                op_err_n = 1'b1;
                state_n  = ST_IDLE;
            end else begin
                asm_n = lead;
                idx_n = CNT_W'(1);
                if (first_cnt == CNT_W'(1)) begin
                    state_n = ST_FULL;
                end else begin
                    rem_n   = first_cnt - CNT_W'(1);
                    state_n = ST_COLLECT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            asm_reg   <= '0;
            byte_idx  <= '0;
            remaining <= '0;
            op_err    <= 1'b0;
        end else begin
            state     <= state_n;
            asm_reg   <= asm_n;
            byte_idx  <= idx_n;
            remaining <= rem_n;
            op_err    <= op_err_n;
        end
    end

endmodule
